// File: rtl/rst_seq_ctrl_if.sv
// Reset-sequencer bus: user reset pulse and per-stage done flags in; stage resets and status out.
// master = board/generator side, slave = sequencer side.
interface rst_seq_ctrl_if #(
  parameter int N_STAGE = 4
);
  localparam int IW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  logic               rst_usr;
  logic [N_STAGE-1:0] stage_done;
  logic [N_STAGE-1:0] stage_rst;
  logic               seq_done;
  logic               seq_err;
  logic [IW-1:0]      err_stage;
  logic [2:0]         retry_cnt_o;

  modport master (
    output rst_usr, stage_done,
    input  stage_rst, seq_done, seq_err, err_stage, retry_cnt_o
  );

  modport slave (
    input  rst_usr, stage_done,
    output stage_rst, seq_done, seq_err, err_stage, retry_cnt_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Releases N_STAGE downstream resets in order after rst_usr falls, waiting on each stage's done.
// Latency: GAP_CYC per slot plus 3 cycles done-to-next-slot; no backpressure, timeouts retry then abort.
module rst_seq_ctrl #(
  parameter int N_STAGE     = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 2
) (
  input  logic          gt_tx_clk,
  input  logic          gt_reset_n,
  rst_seq_ctrl_if.slave bus
);
  localparam int IW   = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
  localparam int CMAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]         r_state;
  logic [IW-1:0]      r_idx;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_retry;
  logic [N_STAGE-1:0] r_stage_rst;
  logic               r_seq_done;
  logic               r_seq_err;
  logic [IW-1:0]      r_err_stage;
  logic               r_usr_d;
  logic [N_STAGE-1:0] r_sync1;
  logic [N_STAGE-1:0] r_sync2;

  logic w_fall;
  logic w_done_cur;
  logic w_last;
  logic w_gap_end;
  logic w_tmo;

  assign w_fall     = r_usr_d & ~bus.rst_usr;
  assign w_done_cur = r_sync2[r_idx];
  assign w_last     = (r_idx == IW'(N_STAGE - 1));
  assign w_gap_end  = (r_cnt == CW'(GAP_CYC - 1));
  assign w_tmo      = (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge gt_tx_clk or negedge gt_reset_n) begin
    if (!gt_reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_stage_rst <= '1;
      r_seq_done  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_stage <= '0;
      r_usr_d     <= 1'b0;
      r_sync1     <= '0;
      r_sync2     <= '0;
    end else begin
      r_usr_d <= bus.rst_usr;
      r_sync1 <= bus.stage_done;
      r_sync2 <= r_sync1;
      // rst_usr overrides every state; err_stage deliberately survives it
      if (bus.rst_usr) begin
        r_state     <= S_HOLD;
        r_idx       <= '0;
        r_cnt       <= '0;
        r_retry     <= '0;
        r_stage_rst <= '1;
        r_seq_done  <= 1'b0;
        r_seq_err   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_HOLD: begin
            if (w_fall) begin
              r_state <= S_GAP;
              r_cnt   <= '0;
            end
          end
          S_GAP: begin
            if (w_gap_end) begin
              r_stage_rst[r_idx] <= 1'b0;
              r_cnt              <= '0;
              r_state            <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_WAIT: begin
            if (w_done_cur) begin
              r_retry <= '0;
              r_cnt   <= '0;
              if (w_last) begin
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + IW'(1);
                r_state <= S_GAP;
              end
            end else if (w_tmo) begin
              r_cnt              <= '0;
              r_stage_rst[r_idx] <= 1'b1;
              if (r_retry < 3'(MAX_RETRY)) begin
                r_retry <= r_retry + 3'd1;
                r_state <= S_GAP;
              end else begin
                r_seq_err   <= 1'b1;
                r_err_stage <= r_idx;
                r_state     <= S_ERR;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DONE:  r_seq_done <= 1'b1;
          S_ERR:   ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.stage_rst   = r_stage_rst;
  assign bus.seq_done    = r_seq_done;
  assign bus.seq_err     = r_seq_err;
  assign bus.err_stage   = r_err_stage;
  assign bus.retry_cnt_o = r_retry;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: expected stage_rst edges (cycle, value) are queued as stimulus is
// driven and popped by a negedge monitor whenever stage_rst changes.
module tb_rst_seq_ctrl;
  localparam int N = 4;

  logic gt_tx_clk  = 1'b0;
  logic gt_reset_n = 1'b1;

  rst_seq_ctrl_if #(.N_STAGE(N)) bus ();

  rst_seq_ctrl #(
    .N_STAGE(N), .GAP_CYC(16), .TIMEOUT_CYC(1024), .MAX_RETRY(2)
  ) dut (
    .gt_tx_clk  (gt_tx_clk),
    .gt_reset_n (gt_reset_n),
    .bus        (bus)
  );

  always #5 gt_tx_clk = ~gt_tx_clk;

  int cyc = 0;
  always @(posedge gt_tx_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_rst = 4'hf;

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    if (v !== m_rst) begin
      e.cyc = c;
      e.val = v;
      q.push_back(e);
      m_rst = v;
    end
  endtask

  logic       mon_en = 1'b0;
  logic [3:0] prev   = 4'hf;

  always @(negedge gt_tx_clk) begin
    exp_t e;
    if (mon_en && bus.stage_rst !== prev) begin
      if (q.size() == 0) begin
        check("unexp_chg", bus.stage_rst, prev);
      end else begin
        e = q.pop_front();
        check("chg_cyc", cyc, e.cyc);
        check("chg_val", bus.stage_rst, e.val);
      end
      prev = bus.stage_rst;
    end
  end

  int t_gap;
  int d;

  task automatic start_seq(input logic [3:0] dv);
    @(negedge gt_tx_clk);
    bus.stage_done = dv;
    bus.rst_usr    = 1'b1;
    push(cyc + 1, 4'hf);
    repeat (20) @(negedge gt_tx_clk);
    bus.rst_usr = 1'b0;
    t_gap = cyc + 1;
    push(t_gap + 16, 4'he);
  endtask

  task automatic wait_fall(input int i);
    int n;
    n = 0;
    while (bus.stage_rst[i] !== 1'b0 && n < 4000) begin
      @(negedge gt_tx_clk);
      n++;
    end
    if (n >= 4000) check($sformatf("fall_tmo%0d", i), 32'(bus.stage_rst[i]), 0);
  endtask

  task automatic give_done(input int i, input int dly, input bit nxt);
    logic [3:0] mask;
    repeat (dly) @(negedge gt_tx_clk);
    bus.stage_done[i] = 1'b1;
    d = cyc;
    mask = 4'b0001 << (i + 1);
    if (nxt && i < N - 1) push(d + 19, m_rst & ~mask);
  endtask

  task automatic finish_seq();
    repeat (3) @(negedge gt_tx_clk);
    check("seq_done_early", 32'(bus.seq_done), 0);
    @(negedge gt_tx_clk);
    check("seq_done", 32'(bus.seq_done), 1);
    check("seq_err_clr", 32'(bus.seq_err), 0);
    check("retry_end", 32'(bus.retry_cnt_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int f;
    int k;
    bus.rst_usr    = 1'b0;
    bus.stage_done = '0;
    #1 gt_reset_n = 1'b0;
    #2;
    check("rst_stage_rst", 32'(bus.stage_rst), 32'hf);
    check("rst_seq_done", 32'(bus.seq_done), 0);
    check("rst_seq_err", 32'(bus.seq_err), 0);
    check("rst_err_stage", 32'(bus.err_stage), 0);
    check("rst_retry", 32'(bus.retry_cnt_o), 0);
    @(negedge gt_tx_clk);
    gt_reset_n = 1'b1;
    mon_en     = 1'b1;
    repeat (5) @(negedge gt_tx_clk);
    check("idle_hold", 32'(bus.stage_rst), 32'hf);

    // 1: normal sequence
    start_seq(4'h0);
    for (int i = 0; i < N; i++) begin
      wait_fall(i);
      give_done(i, 5, 1'b1);
    end
    finish_seq();

    // 2: one timeout on stage 1, then success
    start_seq(4'h0);
    wait_fall(0);
    give_done(0, 5, 1'b1);
    wait_fall(1);
    f = cyc;
    push(f + 1024, 4'b1110);
    push(f + 1040, 4'b1100);
    repeat (1023) @(negedge gt_tx_clk);
    check("retry_pre", 32'(bus.retry_cnt_o), 0);
    @(negedge gt_tx_clk);
    check("retry_one", 32'(bus.retry_cnt_o), 1);
    wait_fall(1);
    give_done(1, 3, 1'b1);
    check("retry_hold", 32'(bus.retry_cnt_o), 1);
    repeat (3) @(negedge gt_tx_clk);
    check("retry_clr", 32'(bus.retry_cnt_o), 0);
    wait_fall(2);
    give_done(2, 5, 1'b1);
    wait_fall(3);
    give_done(3, 5, 1'b1);
    finish_seq();

    // 3: stage 2 never done -> retries exhausted
    start_seq(4'h0);
    wait_fall(0);
    give_done(0, 5, 1'b1);
    wait_fall(1);
    give_done(1, 5, 1'b1);
    wait_fall(2);
    f = cyc;
    push(f + 1024, 4'b1100);
    push(f + 1040, 4'b1000);
    push(f + 2064, 4'b1100);
    push(f + 2080, 4'b1000);
    push(f + 3104, 4'b1100);
    repeat (3103) @(negedge gt_tx_clk);
    check("err_early", 32'(bus.seq_err), 0);
    check("retry_two", 32'(bus.retry_cnt_o), 2);
    @(negedge gt_tx_clk);
    check("seq_err", 32'(bus.seq_err), 1);
    check("err_stage", 32'(bus.err_stage), 2);
    check("err_no_done", 32'(bus.seq_done), 0);
    repeat (10) @(negedge gt_tx_clk);
    check("err_rst", 32'(bus.stage_rst), 32'hc);
    check("err_held", 32'(bus.seq_err), 1);

    // 4: rst_usr during WAIT(1), restart from stage 0
    start_seq(4'h0);
    check("usr_clr_err", 32'(bus.seq_err), 0);
    check("err_stage_kept", 32'(bus.err_stage), 2);
    wait_fall(0);
    give_done(0, 5, 1'b1);
    wait_fall(1);
    repeat (10) @(negedge gt_tx_clk);
    start_seq(4'h0);
    for (int i = 0; i < N; i++) begin
      wait_fall(i);
      give_done(i, 5, 1'b1);
    end
    finish_seq();

    // 5: async reset mid-GAP(2)
    start_seq(4'h0);
    wait_fall(0);
    give_done(0, 5, 1'b1);
    wait_fall(1);
    give_done(1, 5, 1'b0);
    repeat (10) @(negedge gt_tx_clk);
    k = cyc;
    #2 gt_reset_n = 1'b0;
    #1;
    check("arst_stage_rst", 32'(bus.stage_rst), 32'hf);
    check("arst_seq_done", 32'(bus.seq_done), 0);
    check("arst_seq_err", 32'(bus.seq_err), 0);
    check("arst_err_stage", 32'(bus.err_stage), 0);
    push(k + 1, 4'hf);
    @(negedge gt_tx_clk);
    gt_reset_n     = 1'b1;
    bus.stage_done = 4'hf;
    repeat (40) @(negedge gt_tx_clk);
    check("no_seq", 32'(bus.stage_rst), 32'hf);
    check("no_seq_done", 32'(bus.seq_done), 0);

    // 6: all done flags high before start
    start_seq(4'hf);
    push(t_gap + 33, 4'b1100);
    push(t_gap + 50, 4'b1000);
    push(t_gap + 67, 4'b0000);
    repeat (69) @(negedge gt_tx_clk);
    check("fast_done_early", 32'(bus.seq_done), 0);
    @(negedge gt_tx_clk);
    check("fast_done", 32'(bus.seq_done), 1);
    check("fast_retry", 32'(bus.retry_cnt_o), 0);

    repeat (5) @(negedge gt_tx_clk);
    check("q_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
